fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of fifo_top between
//  NUM_REQ producers. Grants one producer at a time for a burst of up to
//  MAX_BURST accepted writes. Muxes the owner's data onto wr/write_data and

---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of fifo_top between
// NUM_REQ producers. One producer owns the port at a time for a burst of up to
// MAX_BURST accepted writes. The owner's word is muxed onto wr/write_data and
// the FIFO's full flag is honoured as back-pressure. There is always one IDLE
// cycle between two grants, which is where the next owner is chosen.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; aborts any grant in progress
//   req        in   req[i]=1: producer i has a word on its req_data slice
//   req_data   in   producer i's word at req_data[i*data_width +: data_width]
//   full       in   FIFO full flag; stalls the current owner
//   wr         out  write strobe to fifo_top
//   write_data out  word written to fifo_top (0 when wr=0)
//   gnt        out  one-hot; gnt[i]=1 means producer i's word is written now
//   owner      out  index of the current owner, valid while busy
//   busy       out  1 while a producer owns the write port
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*data_width-1:0] req_data,
    input  logic                          full,
    output logic                          wr,
    output logic [data_width-1:0]         write_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      next_owner;
    logic [CNT_W-1:0]      burst_cnt;
    logic [data_width-1:0] owner_data;
    logic                  owner_req;
    logic                  accept;
    logic                  rel;
    logic                  found;
    int                    cand;

    // Pick the first requester starting at rr_ptr and wrapping around, so the
    // producer just after the previous owner has the highest priority.
    always_comb begin
        next_owner = rr_ptr;
        found      = 1'b0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found      = 1'b1;
                next_owner = cand[IDX_W-1:0];
            end
        end
    end

    // Select the owner's data slice with a compare-per-slice mux, which keeps
    // the index arithmetic constant per iteration.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_data = req_data[i*data_width +: data_width];
            end
        end
    end

    // The write port outputs are combinational from the registered state so a
    // word is accepted in the same cycle the FIFO reports room for it. They are
    // masked by reset so that no write can slip out in a reset cycle, even
    // though the state register only clears on the following edge.
    always_comb begin
        owner_req  = req[owner];
        busy       = (state == OWN) && !reset;
        accept     = busy && owner_req && !full;
        rel        = busy && ((accept && (burst_cnt == CNT_W'(MAX_BURST - 1))) || !owner_req);
        wr         = accept;
        gnt        = accept ? (NUM_REQ'(1) << owner) : '0;
        write_data = accept ? owner_data : '0;
    end

    // Grant state machine. A grant ends either when the burst cap is reached
    // or when the owner drops its request; the full flag alone never ends it,
    // so a stalled owner keeps the port until the FIFO drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= next_owner;
                        burst_cnt <= '0;
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (accept) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                    if (rel) begin
                        rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed scenarios followed by a randomized phase. Producers are modelled as
// word counters that hold req/data until granted. A behavioural model of the
// arbitration rules predicts every cycle's outputs and the word stream the
// FIFO should receive.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic                  full;
    logic                  wr;
    logic [DW-1:0]         write_data;
    logic [NUM_REQ-1:0]    gnt;
    logic [1:0]            owner;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    // Producer state: words still to send and the value of the next word.
    int       remaining [NUM_REQ];
    logic [7:0] nxt     [NUM_REQ];

    // Reference model: who owns the port, how many words this grant has
    // taken, and where the next search starts.
    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_ptr;

    // Observation logs.
    logic [7:0] dut_words[$];
    logic [7:0] model_words[$];
    int         grant_log[$];
    logic       prev_busy;
    logic [31:0] wr_hist;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .data_width(DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .full      (full),
        .wr        (wr),
        .write_data(write_data),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle: inputs come from the producer state, outputs are
    // checked at the falling edge against the model, then the model and the
    // producers advance on the rising edge.
    task automatic applyStimulus(input logic rst, input logic f, input string tag);
        logic       acc;
        logic       exp_wr;
        logic       exp_busy;
        logic [3:0] exp_gnt;
        logic [7:0] exp_data;
        logic [3:0] gnt_seen;
        reset = rst;
        full  = f;
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]                = (remaining[i] > 0);
            req_data[i*DW +: DW]  = nxt[i];
        end
        @(negedge clk);
        acc      = 1'b0;
        exp_wr   = 1'b0;
        exp_busy = 1'b0;
        exp_gnt  = 4'b0000;
        exp_data = 8'h00;
        if (!rst && m_busy) begin
            exp_busy = 1'b1;
            acc      = req[m_owner] && !f;
            if (acc) begin
                exp_wr   = 1'b1;
                exp_gnt  = 4'b0001 << m_owner;
                exp_data = nxt[m_owner];
            end
        end
        checkOutput({tag, " wr"}, 32'(wr), 32'(exp_wr));
        checkOutput({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
        checkOutput({tag, " write_data"}, 32'(write_data), 32'(exp_data));
        checkOutput({tag, " busy"}, 32'(busy), 32'(exp_busy));
        if (exp_busy) begin
            checkOutput({tag, " owner"}, 32'(owner), 32'(m_owner));
        end
        checkOutput({tag, " invariants"},
                    32'({$onehot0(gnt), wr == (|gnt), !(wr && full)}), 32'(3'b111));
        if (busy && !prev_busy) begin
            grant_log.push_back(int'(owner));
        end
        prev_busy = busy;
        wr_hist   = {wr_hist[30:0], wr};
        if (wr) begin
            dut_words.push_back(write_data);
        end
        if (exp_wr) begin
            model_words.push_back(exp_data);
        end
        gnt_seen = gnt;
        @(posedge clk);
        if (rst) begin
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_owner = 0;
        end else if (!m_busy) begin
            if (req != 4'b0000) begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % NUM_REQ]) begin
                        m_owner = (m_ptr + k) % NUM_REQ;
                    end
                end
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else begin
            if (acc) begin
                m_cnt++;
            end
            if ((acc && m_cnt == MAX_BURST) || !req[m_owner]) begin
                m_ptr  = (m_owner + 1) % NUM_REQ;
                m_busy = 1'b0;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_seen[i]) begin
                remaining[i]--;
                nxt[i]++;
            end
        end
        #1;
    endtask

    // Withdraw all words, hold reset, and clear the observation logs.
    task automatic resetDut(input int n);
        for (int i = 0; i < NUM_REQ; i++) begin
            remaining[i] = 0;
        end
        for (int c = 0; c < n; c++) begin
            applyStimulus(1'b1, 1'b0, "RST");
        end
        dut_words.delete();
        model_words.delete();
        grant_log.delete();
        wr_hist = '0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        full      = 1'b0;
        m_busy    = 1'b0;
        m_owner   = 0;
        m_cnt     = 0;
        m_ptr     = 0;
        prev_busy = 1'b0;
        wr_hist   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            remaining[i] = 0;
            nxt[i]       = 8'h00;
        end

        // T1: all requesting during reset; first grant goes to producer 0.
        $display("[TB] T1 reset");
        for (int i = 0; i < NUM_REQ; i++) begin
            remaining[i] = 3;
            nxt[i]       = 8'(8'h10 * (i + 1));
        end
        applyStimulus(1'b1, 1'b0, "T1 rst");
        applyStimulus(1'b1, 1'b0, "T1 rst");
        applyStimulus(1'b0, 1'b0, "T1");
        checkOutput("T1 first owner", 32'(owner), 32'd0);
        checkOutput("T1 busy after grant", 32'(busy), 32'd1);
        resetDut(2);

        // T2: single producer with 6 words; burst cap splits it 4 + 2.
        $display("[TB] T2 burst cap");
        remaining[2] = 6;
        nxt[2]       = 8'hD0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, "T2");
        end
        checkOutput("T2 wr pattern", wr_hist, 32'b0111_1011);
        applyStimulus(1'b0, 1'b0, "T2");
        applyStimulus(1'b0, 1'b0, "T2");
        checkOutput("T2 word count", 32'(dut_words.size()), 32'd6);
        for (int k = 0; k < 6 && k < dut_words.size(); k++) begin
            checkOutput("T2 word order", 32'(dut_words[k]), 32'(8'hD0 + k));
        end
        checkOutput("T2 grants", 32'(grant_log.size()), 32'd2);
        resetDut(1);

        // T3: producers 0, 1, 3 requesting continuously.
        $display("[TB] T3 round robin");
        remaining[0] = 100;
        remaining[1] = 100;
        remaining[3] = 100;
        for (int c = 0; c < 31; c++) begin
            applyStimulus(1'b0, 1'b0, "T3");
        end
        checkOutput("T3 grant count", 32'(grant_log.size()), 32'd6);
        for (int g = 0; g < 6 && g < grant_log.size(); g++) begin
            checkOutput("T3 owner sequence", 32'(grant_log[g]), 32'((g % 3 == 2) ? 3 : g % 3));
        end
        checkOutput("T3 words", 32'(dut_words.size()), 32'd24);
        resetDut(1);

        // T4: owner 1 stalled by full after 2 writes.
        $display("[TB] T4 full stall");
        remaining[1] = 4;
        nxt[1]       = 8'h40;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, "T4");
        end
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b1, "T4 stall");
        end
        checkOutput("T4 words before release", 32'(dut_words.size()), 32'd2);
        checkOutput("T4 owner held", 32'(owner), 32'd1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, "T4");
        end
        checkOutput("T4 words total", 32'(dut_words.size()), 32'd4);
        checkOutput("T4 grants", 32'(grant_log.size()), 32'd1);
        resetDut(1);

        // T5: owner 0 drops after one word; producer 1 is next.
        $display("[TB] T5 req drop");
        remaining[0] = 1;
        remaining[1] = 2;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b0, "T5");
        end
        checkOutput("T5 owner after drop", 32'(owner), 32'd1);
        checkOutput("T5 busy after drop", 32'(busy), 32'd1);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b0, "T5");
        end
        checkOutput("T5 grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            checkOutput("T5 first owner", 32'(grant_log[0]), 32'd0);
            checkOutput("T5 second owner", 32'(grant_log[1]), 32'd1);
        end
        resetDut(1);

        // T6: reset during owner 3's second write.
        $display("[TB] T6 reset mid-burst");
        remaining[3] = 4;
        nxt[3]       = 8'hA0;
        applyStimulus(1'b0, 1'b0, "T6");
        applyStimulus(1'b0, 1'b0, "T6");
        applyStimulus(1'b1, 1'b0, "T6 rst");
        applyStimulus(1'b0, 1'b0, "T6 idle");
        checkOutput("T6 words", 32'(dut_words.size()), 32'd1);
        checkOutput("T6 regrant owner", 32'(owner), 32'd3);
        resetDut(1);

        // Randomized traffic with back-pressure, withdrawals and resets.
        $display("[TB] random phase");
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (remaining[i] == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        remaining[i] = int'($urandom_range(1, 7));
                        nxt[i]       = 8'($urandom);
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    remaining[i] = 0;
                end
            end
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), "RND");
        end
        checkOutput("RND word count", 32'(dut_words.size()), 32'(model_words.size()));
        for (int k = 0; k < dut_words.size() && k < model_words.size(); k++) begin
            checkOutput("RND word stream", 32'(dut_words[k]), 32'(model_words[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
